// File: rtl/i2c_xfer_sequencer_if.sv
// Request/status and byte-engine command/response bundle of the I2C transfer sequencer.
// slave is the sequencer's view; master is the view of the CSR block plus byte engine.
interface i2c_xfer_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg;
  logic [1:0]  req_len;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [31:0] rdata;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        cmd_nack_last;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_nack;
  logic        eng_abort;

  modport slave (
    input  req_valid, req_rw, req_dev, req_reg, req_len, req_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack,
    output req_ready, busy, done, err, rdata,
    output cmd_valid, cmd_op, cmd_data, cmd_nack_last, eng_abort
  );

  modport master (
    output req_valid, req_rw, req_dev, req_reg, req_len, req_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack,
    input  req_ready, busy, done, err, rdata,
    input  cmd_valid, cmd_op, cmd_data, cmd_nack_last, eng_abort
  );
endinterface

// File: rtl/i2c_xfer_sequencer.sv
// Splits one register read/write request into I2C byte-engine commands,
// one outstanding at a time, with NACK tracking and a per-phase watchdog.
module i2c_xfer_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                 clk,
  input logic                 rst,
  i2c_xfer_sequencer_if.slave bus
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] OP_START   = 3'd0;
  localparam logic [2:0] OP_WRITE   = 3'd1;
  localparam logic [2:0] OP_READ    = 3'd2;
  localparam logic [2:0] OP_STOP    = 3'd3;
  localparam logic [2:0] OP_RESTART = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;
  typedef enum logic [2:0] {SP_START, SP_DEV, SP_REG, SP_DATA,
                            SP_RESTART, SP_DEVR, SP_READ, SP_STOP} step_e;

  state_e      state_q;
  step_e       step_q, step_d;
  logic [1:0]  idx_q, idx_d;
  logic        rw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [1:0]  len_q;
  logic [31:0] wdata_q;
  logic [WDW-1:0] wd_q;
  logic        req_ready_q, busy_q, done_q, abort_q;
  logic [1:0]  err_q, nack_err;
  logic [31:0] rdata_q;
  logic        cmd_valid_q, cmd_nl_q, cmd_nl_d;
  logic [2:0]  cmd_op_q, cmd_op_d;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic        wd_hit;

  assign wd_hit = (wd_q == WD_LAST);

  // Step that follows a response in WAIT, and the command it will present.
  always_comb begin
    step_d   = step_q;
    idx_d    = idx_q;
    nack_err = 2'd0;
    case (step_q)
      SP_START:   step_d = SP_DEV;
      SP_DEV:     step_d = SP_REG;
      SP_REG:     begin step_d = rw_q ? SP_RESTART : SP_DATA; idx_d = 2'd0; end
      SP_DATA:    if (idx_q == len_q) step_d = SP_STOP; else idx_d = idx_q + 2'd1;
      SP_RESTART: step_d = SP_DEVR;
      SP_DEVR:    begin step_d = SP_READ; idx_d = 2'd0; end
      SP_READ:    if (idx_q == len_q) step_d = SP_STOP; else idx_d = idx_q + 2'd1;
      default:    step_d = SP_STOP;
    endcase
    if (bus.rsp_nack && (step_q inside {SP_DEV, SP_REG, SP_DATA, SP_DEVR})) begin
      step_d   = SP_STOP;
      nack_err = (step_q == SP_DATA) ? 2'd2 : 2'd1;
    end

    cmd_op_d   = OP_STOP;
    cmd_data_d = 8'd0;
    cmd_nl_d   = 1'b0;
    case (step_d)
      SP_START:   cmd_op_d = OP_START;
      SP_DEV:     begin cmd_op_d = OP_WRITE; cmd_data_d = {dev_q, 1'b0}; end
      SP_REG:     begin cmd_op_d = OP_WRITE; cmd_data_d = reg_q; end
      SP_DATA:    begin cmd_op_d = OP_WRITE; cmd_data_d = wdata_q[{idx_d, 3'b000} +: 8]; end
      SP_RESTART: cmd_op_d = OP_RESTART;
      SP_DEVR:    begin cmd_op_d = OP_WRITE; cmd_data_d = {dev_q, 1'b1}; end
      SP_READ:    begin cmd_op_d = OP_READ; cmd_nl_d = (idx_d == len_q); end
      default:    cmd_op_d = OP_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= SP_START;
      idx_q       <= 2'd0;
      rw_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      len_q       <= 2'd0;
      wdata_q     <= 32'd0;
      wd_q        <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 2'd0;
      rdata_q     <= 32'd0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_START;
      cmd_data_q  <= 8'd0;
      cmd_nl_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.req_valid) begin
          rw_q        <= bus.req_rw;
          dev_q       <= bus.req_dev;
          reg_q       <= bus.req_reg;
          len_q       <= bus.req_len;
          wdata_q     <= bus.req_wdata;
          rdata_q     <= 32'd0;
          err_q       <= 2'd0;
          req_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          step_q      <= SP_START;
          idx_q       <= 2'd0;
          wd_q        <= '0;
          cmd_valid_q <= 1'b1;
          cmd_op_q    <= OP_START;
          cmd_data_q  <= 8'd0;
          cmd_nl_q    <= 1'b0;
          state_q     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            wd_q        <= '0;
            state_q     <= ST_WAIT;
          end else if (wd_hit) begin
            cmd_valid_q <= 1'b0;
            abort_q     <= 1'b1;
            done_q      <= 1'b1;
            err_q       <= 2'd3;
            wd_q        <= '0;
            state_q     <= ST_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.rsp_valid) begin
            if (step_q == SP_READ) rdata_q[{idx_q, 3'b000} +: 8] <= bus.rsp_data;
            if (nack_err != 2'd0) err_q <= nack_err;
            wd_q <= '0;
            if (step_q == SP_STOP) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              step_q      <= step_d;
              idx_q       <= idx_d;
              cmd_valid_q <= 1'b1;
              cmd_op_q    <= cmd_op_d;
              cmd_data_q  <= cmd_data_d;
              cmd_nl_q    <= cmd_nl_d;
              state_q     <= ST_ISSUE;
            end
          end else if (wd_hit) begin
            abort_q <= 1'b1;
            done_q  <= 1'b1;
            err_q   <= 2'd3;
            wd_q    <= '0;
            state_q <= ST_DONE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_DONE: begin
          busy_q      <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.rdata         = rdata_q;
  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.cmd_op        = cmd_op_q;
  assign bus.cmd_data      = cmd_data_q;
  assign bus.cmd_nack_last = cmd_nl_q;
  assign bus.eng_abort     = abort_q;
endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Bench: behavioural engine + expected command list per request, random and directed transfers.
module tb_i2c_xfer_sequencer;
  localparam int TO = 16;
  localparam logic [2:0] OP_START = 3'd0, OP_WR = 3'd1, OP_RD = 3'd2, OP_STOP = 3'd3, OP_RS = 3'd4;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] data;
    logic       nl;
    logic       is_data;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  bit idle_chk = 1'b0;
  logic [1:0]  m_err = 2'd0;
  logic [31:0] m_rdata = 32'd0;
  logic [7:0]  obs_w[$];

  i2c_xfer_sequencer_if bus();
  i2c_xfer_sequencer #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic [2:0] op, input logic [7:0] d, input logic nl, input logic isd);
    cmd_t c;
    c.op = op; c.data = d; c.nl = nl; c.is_data = isd;
    return c;
  endfunction

  function automatic int pick_delay(input int dmode);
    if (dmode == 0) return 0;
    if (dmode == 2 && $urandom_range(0, 4) == 0) return TO - 1;
    return int'($urandom_range(0, 2));
  endfunction

  // Cycle-by-cycle relations that hold regardless of the transfer in flight.
  always @(negedge clk) if (!rst) begin
    chk("ready_not_busy", 32'(bus.req_ready), 32'(!bus.busy));
    if (bus.done)      chk("done_in_busy", 32'(bus.busy), 32'd1);
    if (bus.cmd_valid) chk("cmd_in_busy", 32'(bus.busy), 32'd1);
    if (bus.eng_abort) chk("abort_with_done", 32'(bus.done), 32'd1);
    if (idle_chk && !bus.busy) begin
      chk("idle_err_held", 32'(bus.err), 32'(m_err));
      chk("idle_rdata_held", bus.rdata, m_rdata);
    end
  end

  task automatic chk_reset();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("rst_cmd_op", 32'(bus.cmd_op), 32'd0);
    chk("rst_cmd_data", 32'(bus.cmd_data), 32'd0);
    chk("rst_nack_last", 32'(bus.cmd_nack_last), 32'd0);
    chk("rst_abort", 32'(bus.eng_abort), 32'd0);
  endtask

  // nack_w: ordinal of the WRITE the slave NACKs; to_k/to_mode: command index that
  // stalls (1 = never ready, 2 = never responds); rst_k: command index at which reset hits.
  task automatic run(input bit rw, input logic [6:0] dev, input logic [7:0] rg, input logic [1:0] len,
                     input logic [31:0] wd, input logic [31:0] rb, input int nack_w,
                     input int to_k_in, input int to_mode, input int rst_k_in, input int dmode);
    cmd_t q[$];
    int widx[$];
    int nack_k = -1;
    int to_k = to_k_in;
    int rst_k = rst_k_in;
    logic [1:0]  e_err = 2'd0;
    logic [31:0] e_rd = 32'd0;
    int rd_i = 0;
    bit timed = 1'b0;
    int w;
    int d;
    obs_w.delete();

    q.push_back(mk(OP_START, 8'd0, 1'b0, 1'b0));
    q.push_back(mk(OP_WR, {dev, 1'b0}, 1'b0, 1'b0));
    q.push_back(mk(OP_WR, rg, 1'b0, 1'b0));
    if (!rw) begin
      for (int i = 0; i <= int'(len); i++) q.push_back(mk(OP_WR, wd[8*i +: 8], 1'b0, 1'b1));
    end else begin
      q.push_back(mk(OP_RS, 8'd0, 1'b0, 1'b0));
      q.push_back(mk(OP_WR, {dev, 1'b1}, 1'b0, 1'b0));
      for (int i = 0; i <= int'(len); i++) q.push_back(mk(OP_RD, 8'd0, i == int'(len), 1'b0));
    end
    q.push_back(mk(OP_STOP, 8'd0, 1'b0, 1'b0));

    for (int i = 0; i < q.size(); i++) if (q[i].op == OP_WR) widx.push_back(i);
    if (nack_w >= 0 && nack_w < widx.size()) nack_k = widx[nack_w];
    if (to_k >= 0 && nack_k >= 0 && to_k <= nack_k) nack_k = -1;
    if (nack_k >= 0) begin
      e_err = q[nack_k].is_data ? 2'd2 : 2'd1;
      while (q.size() > nack_k + 1) void'(q.pop_back());
      q.push_back(mk(OP_STOP, 8'd0, 1'b0, 1'b0));
    end
    if (to_k >= q.size()) to_k = -1;
    if (to_k >= 0) e_err = 2'd3;
    if (rst_k >= q.size()) rst_k = -1;

    bus.req_rw = rw; bus.req_dev = dev; bus.req_reg = rg; bus.req_len = len; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("accept_busy", 32'(bus.busy), 32'd1);
    // keep a conflicting request pending: it must not disturb the transfer in flight
    bus.req_rw = ~rw; bus.req_dev = ~dev; bus.req_reg = ~rg; bus.req_wdata = ~wd;

    for (int k = 0; k < q.size(); k++) begin
      if (k == 2) bus.req_valid = 1'b0;
      w = 0;
      while (!bus.cmd_valid && w < 4) begin @(negedge clk); w++; end
      chk("issue_latency", 32'(w), 32'd0);
      if (!bus.cmd_valid) begin
        bus.req_valid = 1'b0;
        rst = 1'b1; m_err = 2'd0; m_rdata = 32'd0;
        @(negedge clk); rst = 1'b0;
        return;
      end
      chk("cmd_op", 32'(bus.cmd_op), 32'(q[k].op));
      if (q[k].op == OP_WR) chk("cmd_data", 32'(bus.cmd_data), 32'(q[k].data));
      if (q[k].op == OP_RD) chk("cmd_nack_last", 32'(bus.cmd_nack_last), 32'(q[k].nl));
      if (k == rst_k) begin
        bus.req_valid = 1'b0;
        m_err = 2'd0; m_rdata = 32'd0;
        rst = 1'b1;
        #1;
        chk_reset();
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (k == to_k && to_mode == 1) begin
        bus.req_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
          chk("stall_valid_held", 32'(bus.cmd_valid), 32'd1);
          chk("stall_no_abort", 32'(bus.eng_abort), 32'd0);
          @(negedge clk);
        end
        timed = 1'b1;
        break;
      end
      d = pick_delay(dmode);
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        chk("hold_valid", 32'(bus.cmd_valid), 32'd1);
        chk("hold_op", 32'(bus.cmd_op), 32'(q[k].op));
      end
      bus.cmd_ready = 1'b1;
      if (q[k].op == OP_WR) obs_w.push_back(bus.cmd_data);
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      chk("accepted_drop", 32'(bus.cmd_valid), 32'd0);
      if (k == to_k && to_mode == 2) begin
        bus.req_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
          chk("wait_no_done", 32'(bus.done), 32'd0);
          @(negedge clk);
        end
        timed = 1'b1;
        break;
      end
      d = pick_delay(dmode);
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        chk("wait_quiet", 32'(bus.cmd_valid), 32'd0);
      end
      bus.rsp_valid = 1'b1;
      bus.rsp_data = (q[k].op == OP_RD) ? rb[8*rd_i +: 8] : 8'($urandom);
      if (q[k].op == OP_RD) begin
        e_rd[8*rd_i +: 8] = rb[8*rd_i +: 8];
        rd_i++;
      end
      bus.rsp_nack = (k == nack_k) ? 1'b1 : (q[k].op != OP_WR) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      bus.rsp_nack = 1'b0;
    end
    bus.req_valid = 1'b0;

    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd1);
    chk("done_err", 32'(bus.err), 32'(e_err));
    chk("done_rdata", bus.rdata, e_rd);
    chk("done_abort", 32'(bus.eng_abort), 32'(timed));
    chk("done_no_cmd", 32'(bus.cmd_valid), 32'd0);
    m_err = e_err;
    m_rdata = e_rd;
    @(negedge clk);
    chk("post_done_low", 32'(bus.done), 32'd0);
    chk("post_busy_low", 32'(bus.busy), 32'd0);
    chk("post_abort_low", 32'(bus.eng_abort), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1, "bench stuck");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_dev = 7'd0; bus.req_reg = 8'd0;
    bus.req_len = 2'd0; bus.req_wdata = 32'd0;
    bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = 8'd0; bus.rsp_nack = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(negedge clk);
    idle_chk = 1'b1;

    // write of two bytes, immediate engine
    run(1'b0, 7'h3C, 8'h10, 2'd1, 32'h0000BEEF, 32'd0, -1, -1, 0, -1, 0);
    chk("t1_nwrites", 32'(obs_w.size()), 32'd4);
    if (obs_w.size() == 4) begin
      chk("t1_dev", 32'(obs_w[0]), 32'h78);
      chk("t1_reg", 32'(obs_w[1]), 32'h10);
      chk("t1_b0", 32'(obs_w[2]), 32'hEF);
      chk("t1_b1", 32'(obs_w[3]), 32'hBE);
    end

    // three-byte read
    run(1'b1, 7'h50, 8'h02, 2'd2, 32'd0, 32'h00332211, -1, -1, 0, -1, 0);
    chk("t2_rdata", bus.rdata, 32'h00332211);
    chk("t2_err", 32'(bus.err), 32'd0);
    if (obs_w.size() == 3) chk("t2_devr", 32'(obs_w[2]), 32'hA1);
    else chk("t2_nwrites", 32'(obs_w.size()), 32'd3);

    // address NACK on the first byte
    run(1'b0, 7'h3C, 8'h10, 2'd1, 32'h0000BEEF, 32'd0, 0, -1, 0, -1, 1);
    chk("t3_nwrites", 32'(obs_w.size()), 32'd1);
    chk("t3_err", 32'(bus.err), 32'd1);

    // data NACK on the second data byte of four
    run(1'b0, 7'h3C, 8'h20, 2'd3, 32'hA1B2C3D4, 32'd0, 3, -1, 0, -1, 1);
    chk("t4_nwrites", 32'(obs_w.size()), 32'd4);
    chk("t4_err", 32'(bus.err), 32'd2);

    // engine never takes the command after START
    run(1'b0, 7'h3C, 8'h10, 2'd0, 32'h5A, 32'd0, -1, 1, 1, -1, 0);
    chk("t5_err", 32'(bus.err), 32'd3);
    // engine never answers the first READ; a timeout during the post-NACK STOP
    run(1'b1, 7'h21, 8'h44, 2'd1, 32'd0, 32'h0000CAFE, -1, 5, 2, -1, 1);
    run(1'b0, 7'h12, 8'h34, 2'd2, 32'h00778899, 32'd0, 1, 3, 1, -1, 1);
    chk("t5c_err", 32'(bus.err), 32'd3);
    // a good transfer after a timeout reports OK again
    run(1'b0, 7'h12, 8'h35, 2'd0, 32'h01, 32'd0, -1, -1, 0, -1, 2);

    // reset during the second READ, then a clean write
    run(1'b1, 7'h50, 8'h06, 2'd3, 32'd0, 32'h44332211, -1, -1, 0, 6, 1);
    run(1'b0, 7'h50, 8'h07, 2'd0, 32'h9C, 32'd0, -1, -1, 0, -1, 0);
    chk("t6_rdata", bus.rdata, 32'd0);
    chk("t6_err", 32'(bus.err), 32'd0);

    for (int t = 0; t < 40; t++) begin
      int nw;
      int tk;
      nw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
      tk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
      run(1'($urandom), 7'($urandom), 8'($urandom), 2'($urandom), $urandom, $urandom,
          nw, tk, int'($urandom_range(1, 2)), -1, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
